// File: rtl/display_driver.sv
// Sequential binary-to-BCD display driver: shift-and-add-3 at one bit per clock, then seven-segment latch.
// Optional SIGNED_DISPLAY_EN: two's-complement input with a leading minus sign.
module display_driver #(
    parameter int DATA_WIDTH  = 32,
    parameter int BCD_DIGITS  = 10,
    parameter int DISP_DIGITS = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [DATA_WIDTH-1:0]      value,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       negative,
    output logic [7*DISP_DIGITS-1:0]   seg,
    output logic [1:0]                 dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [BCD_W-1:0]         bcd_adj;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic [7*DISP_DIGITS-1:0] seg_q, seg_d;
    logic [7*DISP_DIGITS-1:0] disp_seg;
    logic                     disp_ovf;
    logic                     is_neg;
    logic [DATA_WIDTH-1:0]    capture_val;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

`ifdef SIGNED_DISPLAY_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;
    assign is_neg      = sign_q;
    assign negative    = neg_q;
    assign capture_val = value[DATA_WIDTH-1] ? (~value + 1'b1) : value;
`else
    assign is_neg      = 1'b0;
    assign negative    = 1'b0;
    assign capture_val = value;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign seg         = seg_q;
    assign dbg_state_o = state_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A negative value gives up its top display digit to the minus sign.
    always_comb begin
        int msd;
        int limit;
        msd      = 0;
        limit    = is_neg ? DISP_DIGITS - 1 : DISP_DIGITS;
        disp_ovf = 1'b0;
        disp_seg = {DISP_DIGITS{GLYPH_BLANK}};
        for (int i = 0; i < DISP_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= limit && bcd_q[4*i +: 4] != 4'd0) begin
                disp_ovf = 1'b1;
            end
        end
        for (int i = 0; i < DISP_DIGITS; i++) begin
            if (disp_ovf) begin
                disp_seg[7*i +: 7] = GLYPH_DASH;
            end else if (i <= msd) begin
                disp_seg[7*i +: 7] = glyph(bcd_q[4*i +: 4]);
            end else if (is_neg && i == msd + 1) begin
                disp_seg[7*i +: 7] = GLYPH_DASH;
            end
        end
    end

    // Handshake: start is sampled only in IDLE; busy stays high from the capture
    // edge until the edge that raises the one-cycle done pulse, when seg is valid.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
`ifdef SIGNED_DISPLAY_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = capture_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONVERT;
`ifdef SIGNED_DISPLAY_EN
                    sign_d  = value[DATA_WIDTH-1];
`endif
                end
            end
            S_CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                seg_d   = disp_seg;
                ovf_d   = disp_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef SIGNED_DISPLAY_EN
                neg_d   = sign_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= {DISP_DIGITS{GLYPH_BLANK}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
        end
    end

`ifdef SIGNED_DISPLAY_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver: vector table of conversions plus hand-written
// sequences for ignored start, mid-conversion reset and held start.
module tb_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    typedef struct {
        logic [31:0] val;
        logic [55:0] seg;
        logic        ovf;
        logic        neg;
    } vec_t;

    logic        clock;
    logic        resetn;
    logic [31:0] value;
    logic        start;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        negative;
    logic [55:0] seg;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;
    int busy_cycles;

    display_driver #(
        .DATA_WIDTH (32),
        .BCD_DIGITS (10),
        .DISP_DIGITS(8)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .value      (value),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .negative   (negative),
        .seg        (seg),
        .dbg_state_o(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until done is seen one step after a rising edge.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        busy_cycles = 0;
        while (!done && k < 100) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            #1;
            k++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic run_conv(input logic [31:0] v, input string name);
        @(negedge clock);
        value = v;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        value = $urandom;
        wait_done(name);
        check({name, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({name, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int n_done;
        logic [55:0] seg_at_done;

        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        start  = 1'b0;
        value  = '0;

        vecs.push_back('{32'd0,        {BL, BL, BL, BL, BL, BL, BL, S0}, 1'b0, 1'b0});
        vecs.push_back('{32'd1234,     {BL, BL, BL, BL, S1, S2, S3, S4}, 1'b0, 1'b0});
        vecs.push_back('{32'd99999999, {S9, S9, S9, S9, S9, S9, S9, S9}, 1'b0, 1'b0});
        vecs.push_back('{32'd100000000,{DS, DS, DS, DS, DS, DS, DS, DS}, 1'b1, 1'b0});
        vecs.push_back('{32'd80500,    {BL, BL, BL, S8, S0, S5, S0, S0}, 1'b0, 1'b0});
        vecs.push_back('{32'd10000000, {S1, S0, S0, S0, S0, S0, S0, S0}, 1'b0, 1'b0});
        vecs.push_back('{32'd7,        {BL, BL, BL, BL, BL, BL, BL, S7}, 1'b0, 1'b0});
`ifdef SIGNED_DISPLAY_EN
        vecs.push_back('{32'hFFFFFFFB, {BL, BL, BL, BL, BL, BL, DS, S5}, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, {BL, BL, BL, BL, BL, BL, DS, S1}, 1'b0, 1'b1});
        vecs.push_back('{32'hFF676980, {DS, DS, DS, DS, DS, DS, DS, DS}, 1'b1, 1'b1});
        vecs.push_back('{32'hFFED2979, {DS, S1, S2, S3, S4, S5, S6, S7}, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, {DS, DS, DS, DS, DS, DS, DS, DS}, 1'b1, 1'b1});
`else
        vecs.push_back('{32'hFFFFFFFF, {DS, DS, DS, DS, DS, DS, DS, DS}, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, {DS, DS, DS, DS, DS, DS, DS, DS}, 1'b1, 1'b0});
`endif

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_neg", 64'(negative), 64'd0);
        check("rst_seg", 64'(seg), 64'({8{BL}}));
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("idle_hold_busy", 64'(busy), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_conv(vecs[i].val, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_seg", i), 64'(seg), 64'(vecs[i].seg));
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_neg", i), 64'(negative), 64'(vecs[i].neg));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_seg_hold", i), 64'(seg), 64'(vecs[i].seg));
        end

        // start during a conversion is ignored
        @(negedge clock);
        value = 32'd4321;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        value = 32'd55;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_done = 0;
        seg_at_done = '0;
        for (int k = 0; k < 70; k++) begin
            if (done) begin
                n_done++;
                seg_at_done = seg;
            end
            @(posedge clock);
            #1;
        end
        check("ign_done_count", 64'(n_done), 64'd1);
        check("ign_seg", 64'(seg_at_done), 64'({BL, BL, BL, BL, S4, S3, S2, S1}));

        // Reset in the middle of a conversion
        @(negedge clock);
        value = 32'd9999;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_seg", 64'(seg), 64'({8{BL}}));
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        run_conv(32'd7, "post_rst");
        check("post_rst_seg", 64'(seg), 64'({BL, BL, BL, BL, BL, BL, BL, S7}));
        check("post_rst_ovf", 64'(overflow), 64'd0);

        // start held high re-triggers right after done
        @(negedge clock);
        value = 32'd42;
        start = 1'b1;
        @(posedge clock);
        #1;
        wait_done("held1");
        check("held1_seg", 64'(seg), 64'({BL, BL, BL, BL, BL, BL, S4, S2}));
        @(posedge clock);
        #1;
        start = 1'b0;
        check("held_retrigger_busy", 64'(busy), 64'd1);
        wait_done("held2");
        check("held2_busy_cycles", 64'(busy_cycles), 64'd33);
        check("held2_seg", 64'(seg), 64'({BL, BL, BL, BL, BL, BL, S4, S2}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_driver.md
Name: display_driver

Overview:
- Consumer side of the register file's display port: takes the 32-bit word the register file exposes for display (register 31) and drives a bank of seven-segment digits.
- Converts binary to BCD sequentially, using shift-and-add-3 at one bit per clock.
- Latches the result into segment registers, blanks leading zeros and flags values too wide for the display.
- Sits between the datapath and the board's HEX displays.

Parameters:
- DATA_WIDTH, 32, width of the input value.
- BCD_DIGITS, 10, internal BCD digits; must hold 2^DATA_WIDTH-1.
- DISP_DIGITS, 8, number of physical seven-segment digits; must be ≤ BCD_DIGITS.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- value  input  DATA_WIDTH  word to display, normally register-file toDisplay.
- start  input  1  request a conversion; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the segment outputs are updated.
- overflow  output  1  value needs more than DISP_DIGITS digits.
- negative  output  1  sign of the displayed value; always 0 unless SIGNED_DISPLAY_EN.
- seg  output  7*DISP_DIGITS  active-low segments. Digit i occupies bits [7i+6:7i], digit 0 is least significant, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, busy=0, done=0, overflow=0, negative=0.
  - Every seg digit = 7'b1111111 (blank); shift and BCD registers cleared.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - start=1 captures value into a shift register, clears the BCD accumulator and the bit counter, sets busy=1, moves to CONVERT.
  - start=0 holds state.
- CONVERT, each cycle:
  - Every BCD nibble ≥5 gets +3 (combinational).
  - Then {bcd, shift} shifts left one bit, taking the MSB of shift into bcd[0].
  - The counter increments; after exactly DATA_WIDTH shifts, go to DONE.
- DONE, one cycle:
  - Segment registers, overflow and negative are updated; done=1, busy=0 at the next edge, return to IDLE.
- Latency:
  - start sampled at edge N → done high during cycle N+DATA_WIDTH+1, with seg valid in the same cycle.
  - busy is high for DATA_WIDTH+1 cycles.
- start asserted while busy is ignored; no queuing. start held high re-triggers in the first IDLE cycle after DONE. value is only sampled at the start edge; later changes do not affect the conversion in flight.
- Overflow:
  - overflow=1 if any BCD digit at index ≥ DISP_DIGITS is nonzero.
  - When overflow=1, every digit shows a dash, 7'b0111111.
- Leading-zero blanking:
  - Digits above the most significant nonzero digit show blank.
  - Digit 0 always shows a numeral, so value 0 displays "0".
- Encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Previous seg/overflow/negative hold unchanged until the next DONE.
- Reset mid-conversion: immediate return to the reset values; the partial result is discarded and the display blanks.

Optional Feature:
- Macro: SIGNED_DISPLAY_EN.
- Defined:
  - value is two's complement. At capture, if value[DATA_WIDTH-1]=1, the magnitude (-value, DATA_WIDTH-bit unsigned, so 0x80000000 → 2147483648) is converted and negative is latched at DONE.
  - A dash is placed in the digit immediately left of the most significant numeral.
  - Overflow threshold becomes DISP_DIGITS-1 digits when negative.
- Not defined:
  - value is unsigned, negative is tied 0, no sign logic is synthesized.

Test Plan:
- Reset then start with value=0 → done at cycle 33; digit0=1000000, digits1-7=1111111, overflow=0.
- value=1234 → digits0..3 = 4,3,2,1 encodings, digits4-7 blank; busy high for exactly 33 cycles.
- value=99999999 → all eight digits show 9 (0010000), overflow=0. Then value=100000000 → overflow=1, all digits 0111111.
- start pulsed again at cycle 10 of a conversion with a different value → ignored; result matches the first value; exactly one done pulse.
- resetn low at cycle 15 of a conversion → busy=0 and seg all blank immediately. After release, a new start with value=7 shows "7" (1111000).
- SIGNED_DISPLAY_EN defined, value=32'hFFFFFFFB (-5) → digit0=0010010, digit1=0111111 (minus), rest blank, negative=1. value=-10000000 → overflow=1.
